// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use interlock, multi-cycle MDU hold,
// wrong-path fetch squash and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MDU_CYCLES = 4,     // stall cycles per mult/div, 2..255
  parameter bit          DELAY_SLOT = 1'b1,  // 1: delay slot executes, no IF/ID squash
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic [4:0]       rd_exe,
  input  logic             memread_exe,
  input  logic             regwrite_exe,
  input  logic             redirect_id,
  input  logic             mdu_start,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             id_lw_exe,
  output logic             id_lw,
  output logic             keep,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [7:0] MduLoad = 8'(MDU_CYCLES - 1);

  typedef enum logic [1:0] {StRun, StLdWait, StMduBusy} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic hz;
  logic stall_mdu;
  logic stall_ld;
  logic redir_ok;

  // Load in EXE whose destination is a live source operand of the ID instruction.
  assign hz = memread_exe & regwrite_exe & (rd_exe != 5'd0) &
              ((use_rs & (rd_exe == rs_id)) | (use_rt & (rd_exe == rt_id)));

  // Next-state and stall decode; MDU wins over load-use, which wins over redirect.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_mdu = 1'b0;
    stall_ld  = 1'b0;
    id_lw     = 1'b0;
    mdu_done  = 1'b0;
    redir_ok  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mdu_start) begin
          stall_mdu = 1'b1;
          cnt_d     = MduLoad;
          state_d   = StMduBusy;
        end else if (hz) begin
          stall_ld = 1'b1;
          state_d  = StLdWait;
        end else begin
          redir_ok = 1'b1;
        end
      end
      StLdWait: begin
        id_lw   = 1'b1;
        state_d = StRun;
        if (mdu_start) begin
          stall_mdu = 1'b1;
          cnt_d     = MduLoad;
          state_d   = StMduBusy;
        end else begin
          redir_ok = 1'b1;
        end
      end
      StMduBusy: begin
        // hz and mdu_start are deliberately ignored while the MDU holds the pipe.
        if (cnt_q != 8'd0) begin
          stall_mdu = 1'b1;
          cnt_d     = cnt_q - 8'd1;
        end else begin
          mdu_done = 1'b1;
          redir_ok = 1'b1;
          state_d  = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Pipeline register controls derived from the active stall kind.
  always_comb begin
    pc_en       = ~(stall_mdu | stall_ld);
    ifid_en     = ~(stall_mdu | stall_ld);
    idex_en     = ~stall_mdu;
    idex_flush  = stall_ld;
    exmem_flush = stall_mdu;
    id_lw_exe   = stall_ld;
    keep        = stall_mdu | stall_ld;
    ifid_flush  = redir_ok & redirect_id & ~DELAY_SLOT;
  end

  // Saturating count of front-end stall cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (keep && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

  // State, MDU counter and stall counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      cnt_q       <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model. Two instances share the inputs:
// dut1 squashes on redirect with a 16-bit counter, dut2 has a delay slot and
// a 3-bit counter so saturation is reachable.
module tb_hazard_ctrl;

  localparam int unsigned MduN = 4;
  localparam logic [9:0]  IdleVec = 10'b1101000000;

  logic       clk;
  logic       reset;
  logic [4:0] rs_id, rt_id, rd_exe;
  logic       use_rs, use_rt, memread_exe, regwrite_exe, redirect_id, mdu_start;

  logic        pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_flush1, exmem_flush1;
  logic        id_lw_exe1, id_lw1, keep1, mdu_done1;
  logic [15:0] stall_cnt1;
  logic        pc_en2, ifid_en2, ifid_flush2, idex_en2, idex_flush2, exmem_flush2;
  logic        id_lw_exe2, id_lw2, keep2, mdu_done2;
  logic [2:0]  stall_cnt2;

  logic [9:0] obs1, obs2;
  assign obs1 = {pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_flush1, exmem_flush1,
                 id_lw_exe1, id_lw1, keep1, mdu_done1};
  assign obs2 = {pc_en2, ifid_en2, ifid_flush2, idex_en2, idex_flush2, exmem_flush2,
                 id_lw_exe2, id_lw2, keep2, mdu_done2};

  int checks   = 0;
  int failures = 0;

  // Behavioural model: remaining MDU stall cycles, pending done pulse,
  // load-use follow-up cycle and stall totals.
  int m_mdu_left;
  bit m_done_next;
  bit m_lw_prev;
  int m_stalls;

  hazard_ctrl #(.MDU_CYCLES(MduN), .DELAY_SLOT(1'b0), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .use_rs(use_rs),
    .use_rt(use_rt), .rd_exe(rd_exe), .memread_exe(memread_exe),
    .regwrite_exe(regwrite_exe), .redirect_id(redirect_id), .mdu_start(mdu_start),
    .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1), .idex_en(idex_en1),
    .idex_flush(idex_flush1), .exmem_flush(exmem_flush1), .id_lw_exe(id_lw_exe1),
    .id_lw(id_lw1), .keep(keep1), .mdu_done(mdu_done1), .stall_cnt(stall_cnt1)
  );

  hazard_ctrl #(.MDU_CYCLES(MduN), .DELAY_SLOT(1'b1), .CNT_W(3)) dut2 (
    .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .use_rs(use_rs),
    .use_rt(use_rt), .rd_exe(rd_exe), .memread_exe(memread_exe),
    .regwrite_exe(regwrite_exe), .redirect_id(redirect_id), .mdu_start(mdu_start),
    .pc_en(pc_en2), .ifid_en(ifid_en2), .ifid_flush(ifid_flush2), .idex_en(idex_en2),
    .idex_flush(idex_flush2), .exmem_flush(exmem_flush2), .id_lw_exe(id_lw_exe2),
    .id_lw(id_lw2), .keep(keep2), .mdu_done(mdu_done2), .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  function automatic bit m_hz();
    return memread_exe && regwrite_exe && (rd_exe != 0) &&
           ((use_rs && rd_exe == rs_id) || (use_rt && rd_exe == rt_id));
  endfunction

  // Expected output vector for the current cycle; ds selects delay-slot behaviour.
  function automatic logic [9:0] exp_vec(input bit ds);
    bit smdu, sld, done, lw, redir;
    smdu = 0; sld = 0; done = 0; lw = 0; redir = 0;
    if (m_mdu_left > 0) smdu = 1;
    else if (m_done_next) begin done = 1; redir = redirect_id; end
    else if (mdu_start) begin smdu = 1; lw = m_lw_prev; end
    else if (m_lw_prev) begin lw = 1; redir = redirect_id; end
    else if (m_hz()) sld = 1;
    else redir = redirect_id;
    return {!(smdu || sld), !(smdu || sld), redir && !ds, !smdu, sld, smdu,
            sld, lw, smdu || sld, done};
  endfunction

  function automatic int sat7(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic model_update();
    logic [9:0] e;
    e = exp_vec(1'b0);
    if (e[1]) m_stalls++;
    if (m_mdu_left > 0) begin
      m_mdu_left--;
      if (m_mdu_left == 0) m_done_next = 1;
    end else if (m_done_next) m_done_next = 0;
    else if (mdu_start) begin m_mdu_left = MduN - 1; m_lw_prev = 0; end
    else if (m_lw_prev) m_lw_prev = 0;
    else if (m_hz()) m_lw_prev = 1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic [4:0] rd, input logic mr,
                        input logic rw, input logic redir, input logic ms);
    rs_id = rs; rt_id = rt; use_rs = urs; use_rt = urt; rd_exe = rd;
    memread_exe = mr; regwrite_exe = rw; redirect_id = redir; mdu_start = ms;
  endtask

  task automatic model_reset();
    m_mdu_left = 0; m_done_next = 0; m_lw_prev = 0; m_stalls = 0;
  endtask

  task automatic tick();
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    checks++;
    if (obs1 !== IdleVec) begin
      failures++; $display("FAIL reset_outs got=%b want=%b", obs1, IdleVec);
    end
    checks++;
    if (stall_cnt1 !== 16'd0 || stall_cnt2 !== 3'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d want=0", stall_cnt1, stall_cnt2);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (obs1 !== IdleVec || obs2 !== IdleVec) begin
      failures++; $display("FAIL post_reset got=%b/%b want=%b", obs1, obs2, IdleVec);
    end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(5'd8, 5'd9, 1, 1, 5'd8, 1, 1, 0, 0);
    #1;
    checks++;
    if (!(keep1 === 1'b1 && id_lw_exe1 === 1'b1 && idex_flush1 === 1'b1 && pc_en1 === 1'b0)) begin
      failures++;
      $display("FAIL load_use_stall got keep=%b lwe=%b idexf=%b pc=%b want 1 1 1 0",
               keep1, id_lw_exe1, idex_flush1, pc_en1);
    end
    checks++;
    if (obs1 !== exp_vec(1'b0)) begin
      failures++; $display("FAIL load_use_model got=%b want=%b", obs1, exp_vec(1'b0));
    end
    tick();
    set_in(5'd8, 5'd9, 1, 1, 5'd0, 0, 0, 0, 0);
    #1;
    checks++;
    if (!(id_lw1 === 1'b1 && keep1 === 1'b0 && stall_cnt1 === 16'd1)) begin
      failures++;
      $display("FAIL load_use_release got id_lw=%b keep=%b cnt=%0d want 1 0 1",
               id_lw1, keep1, stall_cnt1);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_in(5'd0, 5'd3, 1, 0, 5'd0, 1, 1, 0, 0);
    #1;
    checks++;
    if (obs1 !== IdleVec) begin
      failures++; $display("FAIL zero_reg got=%b want=%b", obs1, IdleVec);
    end
    tick();
  endtask

  task automatic test_mdu();
    int keeps;
    int done_at;
    do_reset();
    keeps = 0; done_at = -1;
    for (int c = 0; c < 7; c++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, (c == 0) ? 1'b1 : 1'b0);
      #1;
      if (keep1 === 1'b1) keeps++;
      if (mdu_done1 === 1'b1 && done_at < 0) done_at = c;
      checks++;
      if (obs1 !== exp_vec(1'b0)) begin
        failures++; $display("FAIL mdu_c%0d got=%b want=%b", c, obs1, exp_vec(1'b0));
      end
      tick();
    end
    checks++;
    if (keeps != 4 || done_at != 4) begin
      failures++; $display("FAIL mdu_len got keeps=%0d done_at=%0d want 4 4", keeps, done_at);
    end
    #1;
    checks++;
    if (stall_cnt1 !== 16'd4) begin
      failures++; $display("FAIL mdu_cnt got=%0d want=4", stall_cnt1);
    end
  endtask

  task automatic test_mdu_vs_hz();
    do_reset();
    set_in(5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 1);
    #1;
    checks++;
    if (!(exmem_flush1 === 1'b1 && id_lw_exe1 === 1'b0 && idex_en1 === 1'b0 && idex_flush1 === 1'b0)) begin
      failures++;
      $display("FAIL mdu_vs_hz got exmf=%b lwe=%b idex_en=%b idexf=%b want 1 0 0 0",
               exmem_flush1, id_lw_exe1, idex_en1, idex_flush1);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (obs1 !== exp_vec(1'b0) || id_lw_exe1 !== 1'b0) begin
        failures++; $display("FAIL mdu_vs_hz_c%0d got=%b want=%b", c, obs1, exp_vec(1'b0));
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    checks++;
    if (ifid_flush1 !== 1'b1 || ifid_flush2 !== 1'b0) begin
      failures++; $display("FAIL redirect got=%b/%b want=1/0", ifid_flush1, ifid_flush2);
    end
    tick();
    set_in(5'd4, 5'd7, 0, 1, 5'd7, 1, 1, 1, 0);
    #1;
    checks++;
    if (ifid_flush1 !== 1'b0 || keep1 !== 1'b1) begin
      failures++; $display("FAIL redirect_hz got flush=%b keep=%b want 0 1", ifid_flush1, keep1);
    end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid_mdu();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    #1;
    checks++;
    if (keep1 !== 1'b1) begin
      failures++; $display("FAIL mid_mdu_busy got keep=%b want=1", keep1);
    end
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs1 !== IdleVec || stall_cnt1 !== 16'd0) begin
      failures++;
      $display("FAIL mid_mdu_reset got=%b cnt=%0d want=%b cnt=0", obs1, stall_cnt1, IdleVec);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (obs1 !== IdleVec || mdu_done1 !== 1'b0) begin
      failures++; $display("FAIL mid_mdu_after got=%b want=%b", obs1, IdleVec);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, (c == 0 || c == 5) ? 1'b1 : 1'b0);
      tick();
    end
    #1;
    checks++;
    if (stall_cnt2 !== 3'd7 || stall_cnt1 !== 16'd8) begin
      failures++; $display("FAIL saturate got=%0d/%0d want=7/8", stall_cnt2, stall_cnt1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 5) == 0));
      #1;
      checks++;
      if (obs1 !== exp_vec(1'b0) || stall_cnt1 !== 16'(m_stalls)) begin
        failures++;
        $display("FAIL rand1_c%0d got=%b cnt=%0d want=%b cnt=%0d",
                 c, obs1, stall_cnt1, exp_vec(1'b0), m_stalls);
      end
      checks++;
      if (obs2 !== exp_vec(1'b1) || stall_cnt2 !== 3'(sat7(m_stalls))) begin
        failures++;
        $display("FAIL rand2_c%0d got=%b cnt=%0d want=%b cnt=%0d",
                 c, obs2, stall_cnt2, exp_vec(1'b1), sat7(m_stalls));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mdu();
    test_mdu_vs_hz();
    test_redirect();
    test_reset_mid_mdu();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
